// File: rtl/dcache_fill_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache for the CPU memory stage.
// A read miss stalls the pipeline while an 8-word block is filled from pipelined main memory.
`timescale 1ns/1ps
module dcache_fill_ctrl #(
  parameter int NUM_LINES   = 64,
  parameter int MEM_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        stall,
  output logic [15:0] mem_addr,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid
);

  localparam int DATA_W = 16;
  localparam int IW     = $clog2(NUM_LINES);
  localparam int TW     = 12 - IW;
  localparam int QW     = $clog2(MEM_LATENCY + 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state, state_nxt;
  logic [3:0]        req_cnt, req_cnt_nxt;
  logic [3:0]        ret_cnt, ret_cnt_nxt;
  logic [11:0]       base, base_nxt;
  logic [QW-1:0]     drain_cnt;
  logic [NUM_LINES-1:0] valid;

  logic [TW-1:0]     tag_arr  [NUM_LINES];
  logic [DATA_W-1:0] data_arr [NUM_LINES*8];

  logic [IW-1:0]     cpu_idx, fill_idx;
  logic [TW-1:0]     cpu_tag;
  logic [2:0]        cpu_off;
  logic              hit;

  logic              arr_we;
  logic [IW+2:0]     arr_widx;
  logic [DATA_W-1:0] arr_wdata;
  logic              fill_start, fill_done;

  logic [DATA_W-1:0] cpu_rdata_c, mem_addr_c, mem_wdata_c;
  logic              stall_c, mem_en_c, mem_wr_c;

  assign cpu_idx  = cpu_addr[3+IW:4];
  assign cpu_tag  = cpu_addr[15:4+IW];
  assign cpu_off  = cpu_addr[3:1];
  assign fill_idx = base[IW-1:0];
  assign hit      = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

  always_comb begin
    state_nxt   = state;
    req_cnt_nxt = req_cnt;
    ret_cnt_nxt = ret_cnt;
    base_nxt    = base;
    stall_c     = 1'b0;
    cpu_rdata_c = '0;
    mem_en_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    arr_we      = 1'b0;
    arr_widx    = {cpu_idx, cpu_off};
    arr_wdata   = cpu_wdata;
    fill_start  = 1'b0;
    fill_done   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_wr) begin
          mem_en_c    = 1'b1;
          mem_wr_c    = 1'b1;
          mem_addr_c  = cpu_addr & 16'hFFFE;
          mem_wdata_c = cpu_wdata;
          arr_we      = hit;
        end else if (cpu_rd) begin
          if (hit) begin
            cpu_rdata_c = data_arr[{cpu_idx, cpu_off}];
          end else begin
            stall_c = 1'b1;
            // Returns from a fill cut short by reset may still be in flight; hold the
            // new fill back until they have drained so they cannot be counted as ours.
            if (drain_cnt == '0) begin
              fill_start  = 1'b1;
              base_nxt    = cpu_addr[15:4];
              req_cnt_nxt = 4'd0;
              ret_cnt_nxt = 4'd0;
              state_nxt   = FILL;
            end
          end
        end
      end
      FILL: begin
        stall_c = 1'b1;
        if (!req_cnt[3]) begin
          mem_en_c    = 1'b1;
          mem_addr_c  = {base, req_cnt[2:0], 1'b0};
          req_cnt_nxt = req_cnt + 4'd1;
        end
        if (mem_valid && !ret_cnt[3]) begin
          arr_we      = 1'b1;
          arr_widx    = {fill_idx, ret_cnt[2:0]};
          arr_wdata   = mem_rdata;
          ret_cnt_nxt = ret_cnt + 4'd1;
          if (ret_cnt[2:0] == 3'd7) begin
            fill_done = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // All outputs are forced low while reset is held.
  assign cpu_rdata = rst_n ? cpu_rdata_c : '0;
  assign stall     = rst_n & stall_c;
  assign mem_en    = rst_n & mem_en_c;
  assign mem_wr    = rst_n & mem_wr_c;
  assign mem_addr  = rst_n ? mem_addr_c : '0;
  assign mem_wdata = rst_n ? mem_wdata_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_cnt   <= 4'd0;
      ret_cnt   <= 4'd0;
      base      <= '0;
      valid     <= '0;
      drain_cnt <= QW'(MEM_LATENCY);
    end else begin
      state   <= state_nxt;
      req_cnt <= req_cnt_nxt;
      ret_cnt <= ret_cnt_nxt;
      base    <= base_nxt;
      if (drain_cnt != '0) drain_cnt <= drain_cnt - 1'b1;
      if (fill_start) valid[cpu_idx] <= 1'b0;
      if (fill_done) valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arr_we) data_arr[arr_widx] <= arr_wdata;
    if (fill_done) tag_arr[fill_idx] <= base[11:IW];
  end

endmodule

// File: tb/tb_dcache_fill_ctrl.sv
// Directed bench for dcache_fill_ctrl with a 4-cycle pipelined main-memory model.
`timescale 1ns/1ps
module tb_dcache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        stall;
  logic [15:0] mem_addr;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dcache_fill_ctrl #(.NUM_LINES(64), .MEM_LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return (a == 16'h0104) ? 16'hBEEF : (a ^ 16'hC3A5);
  endfunction

  // Main memory: initialised on the first edge, one request per cycle, 4-cycle read latency.
  logic [15:0] mem [32768];
  logic        mem_init = 1'b0;
  logic [3:0]  pv = 4'b0;
  logic [15:0] pd0, pd1, pd2, pd3;

  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= pat(16'(i * 2));
      mem_init <= 1'b1;
    end else if (mem_en && mem_wr) begin
      mem[mem_addr[15:1]] <= mem_wdata;
    end
    pv  <= {pv[2:0], mem_en & ~mem_wr};
    pd0 <= mem[mem_addr[15:1]];
    pd1 <= pd0;
    pd2 <= pd1;
    pd3 <= pd2;
  end

  assign mem_valid = pv[3];
  assign mem_rdata = pd3;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    #1;
    check({tag, "_stall"}, 16'(stall), 16'd0);
    check({tag, "_mem_en"}, 16'(mem_en), 16'd0);
  endtask

  task automatic read_hit(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
    #1;
    check({tag, "_stall"}, 16'(stall), 16'd0);
    check({tag, "_mem_en"}, 16'(mem_en), 16'd0);
    check({tag, "_data"}, cpu_rdata, exp);
  endtask

  task automatic read_miss(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    int n;
    int k;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = addr;
    #1;
    n = 0;
    k = 0;
    while (stall === 1'b1 && n < 40) begin
      if (mem_en === 1'b1) begin
        check($sformatf("%s_addr%0d", tag, k), mem_addr, base + 16'(2 * k));
        check($sformatf("%s_rdreq%0d", tag, k), 16'(mem_wr), 16'd0);
        k++;
      end
      n++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall_cycles"}, 16'(n), 16'd13);
    check({tag, "_requests"}, 16'(k), 16'd8);
    check({tag, "_data"}, cpu_rdata, exp);
  endtask

  task automatic write_op(input string tag, input logic rd, input logic [15:0] addr,
                          input logic [15:0] data, input logic [15:0] exp_maddr);
    @(negedge clk);
    cpu_rd = rd; cpu_wr = 1'b1; cpu_addr = addr; cpu_wdata = data;
    #1;
    check({tag, "_stall"}, 16'(stall), 16'd0);
    check({tag, "_mem_en"}, 16'(mem_en), 16'd1);
    check({tag, "_mem_wr"}, 16'(mem_wr), 16'd1);
    check({tag, "_mem_addr"}, mem_addr, exp_maddr);
    check({tag, "_mem_wdata"}, mem_wdata, data);
    check({tag, "_rdata"}, cpu_rdata, 16'h0000);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0104; cpu_wdata = 16'h0;

    // Outputs held low in reset even with a pending read or write.
    #2;
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_rdata", cpu_rdata, 16'h0000);
    check("rst_mem_en_rd", 16'(mem_en), 16'd0);
    cpu_wr = 1'b1; cpu_wdata = 16'h7777;
    #1;
    check("rst_mem_en_wr", 16'(mem_en), 16'd0);
    check("rst_mem_wr", 16'(mem_wr), 16'd0);
    check("rst_mem_addr", mem_addr, 16'h0000);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Cold miss, then hits on the whole block.
    read_miss("cold", 16'h0104, 16'hBEEF);
    for (int i = 0; i < 8; i++)
      read_hit($sformatf("hit%0d", i), 16'h0100 + 16'(2 * i),
               (i == 2) ? 16'hBEEF : (16'h0100 + 16'(2 * i)) ^ 16'hC3A5);

    // Write hit updates cache and memory.
    write_op("wrhit", 1'b0, 16'h0106, 16'h1234, 16'h0106);
    idle_cycle("wrhit_after");
    read_hit("wrhit_rd", 16'h0106, 16'h1234);
    read_hit("wrhit_nbr", 16'h0104, 16'hBEEF);

    // Write miss goes to memory only.
    write_op("wrmiss", 1'b0, 16'h2000, 16'h5555, 16'h2000);
    idle_cycle("wrmiss_after");
    read_miss("wrmiss_rd", 16'h2000, 16'h5555);

    // Conflict eviction on index 0x10; refill sees the written-through word.
    read_miss("evict_a", 16'h0500, 16'h0500 ^ 16'hC3A5);
    read_miss("evict_b", 16'h0100, 16'h0100 ^ 16'hC3A5);
    read_hit("evict_wt", 16'h0106, 16'h1234);
    read_hit("evict_beef", 16'h0104, 16'hBEEF);

    // Simultaneous read and write is a write; odd byte address is word-aligned.
    write_op("rdwr", 1'b1, 16'h0109, 16'hA0A0, 16'h0108);
    idle_cycle("rdwr_after");
    read_hit("rdwr_rd", 16'h0108, 16'hA0A0);

    // Top-of-memory block.
    read_miss("wrap", 16'hFFF6, 16'hFFF6 ^ 16'hC3A5);
    read_hit("wrap_last", 16'hFFFE, 16'hFFFE ^ 16'hC3A5);

    // Reset in cycle 7 of a fill.
    @(negedge clk);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0304;
    repeat (7) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_stall", 16'(stall), 16'd0);
    check("midrst_mem_en", 16'(mem_en), 16'd0);
    check("midrst_mem_addr", mem_addr, 16'h0000);
    check("midrst_rdata", cpu_rdata, 16'h0000);
    @(negedge clk);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (mem_valid === 1'b1) seen++;
      check($sformatf("stale%0d_stall", i), 16'(stall), 16'd0);
      check($sformatf("stale%0d_mem_en", i), 16'(mem_en), 16'd0);
    end
    check("stale_returns_seen", 16'(seen > 0), 16'd1);
    read_miss("after_rst", 16'h0304, 16'h0304 ^ 16'hC3A5);
    read_hit("after_rst_hit", 16'h030E, 16'h030E ^ 16'hC3A5);
    idle_cycle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dcache_fill_ctrl.md
# dcache_fill_ctrl

Direct-mapped, write-through, no-write-allocate cache with a miss-fill state machine for the pipelined CPU's memory-stage port. It sits between the CPU memory stage and the multi-cycle main memory, which has a fixed 4-cycle read latency. It supplies read data on hits in the same cycle. On a read miss it stalls the pipeline while it fills one 8-word block.

## Interface
- NUM_LINES, default 64: number of cache lines (power of 2). Index width IW = log2(NUM_LINES).
- MEM_LATENCY, default 4: cycles from a read request to `mem_valid` with data.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- cpu_addr  in  16  byte address. Bit 0 is ignored. Offset = [3:1], index = [3+IW:4], tag = [15:4+IW].
- cpu_rd  in  1  read request (LW).
- cpu_wr  in  1  write request (SW); has priority if asserted together with `cpu_rd`.
- cpu_wdata  in  16  store data.
- cpu_rdata  out  16  load data; valid when `cpu_rd` is high and `stall` is low, otherwise 16'h0000.
- stall  out  1  freezes the pipeline (combinational).
- mem_addr  out  16  main-memory word address (byte address, bit 0 = 0).
- mem_en  out  1  memory request strobe.
- mem_wr  out  1  1 = write, 0 = read; meaningful only while `mem_en` is high.
- mem_wdata  out  16  write data to memory.
- mem_rdata  in  16  read data from memory.
- mem_valid  in  1  `mem_rdata` valid this cycle. Memory is pipelined: one request is accepted per cycle.

## Operation
- Storage:
  - data array NUM_LINES×8×16;
  - tag array NUM_LINES×(12−IW);
  - valid bit per line.
- hit = valid[index] & (tag[index] == addr tag).
- FSM states: IDLE, FILL.
- IDLE:
  - Read hit: `cpu_rdata` = data[index][offset] combinationally; `stall` = 0.
  - Read miss: `stall` = 1 combinationally. Latch the block base {tag, index, 4'b0}. Clear req_cnt and ret_cnt. Go to FILL.
  - Write hit: the data word is updated at the clock edge. The same cycle drives `mem_en` = 1, `mem_wr` = 1, `mem_addr` = `cpu_addr` & 16'hFFFE, `mem_wdata` = `cpu_wdata`. `stall` = 0.
  - Write miss: memory write only; cache unchanged; `stall` = 0.
  - `mem_valid` is ignored in IDLE.
- FILL:
  - `stall` = 1 throughout.
  - While req_cnt < 8: drive `mem_en` = 1, `mem_wr` = 0, `mem_addr` = base + 2·req_cnt; req_cnt increments.
  - Each `mem_valid` writes `mem_rdata` into data[index][ret_cnt]; ret_cnt increments.
  - On the 8th return: write the tag and set the valid bit at that edge, then go to IDLE.
  - CPU inputs are ignored in FILL; the CPU holds them stable because of the stall.
- Eviction: the fill overwrites the line unconditionally. No writeback is needed because the cache is write-through.
- Counters are 3-bit plus a done flag (4-bit counters). req_cnt saturates at 8; ret_cnt saturates at 8.

## Timing
- Read hit: 0 stall cycles; data is available in the same cycle.
- Read miss at cycle 0 (MEM_LATENCY = 4):
  - requests issued in cycles 1–8 for words 0–7;
  - returns arrive in cycles 5–12;
  - valid is set at the end of cycle 12;
  - cycle 13 hits with `stall` = 0.
- General miss penalty: 9 + MEM_LATENCY stall cycles (13 at default).
- Writes: 0 stall cycles; exactly one memory write cycle.
- Reset:
  - asynchronous; while `rst_n` is low all outputs are 0;
  - FSM goes to IDLE, counters to 0, all valid bits cleared (data and tag contents don't care).
- Reset during FILL: the fill is abandoned and the line stays invalid. `mem_valid` pulses still in flight after reset deassertion arrive in IDLE and are ignored.
- `cpu_rd` & `cpu_wr` together: treated as a write.
- Address wrap: a base of 16'hFFF0 fills words 16'hFFF0..16'hFFFE. `mem_addr` never exceeds the block.

## Test plan
- Cold read miss:
  - Stimulus: memory word 0x0104 = 16'hBEEF, `cpu_rd` at `cpu_addr` = 16'h0104.
  - Required: `stall` high for exactly 13 cycles; `mem_addr` sequence 0x0100, 0x0102 … 0x010E; then `cpu_rdata` = 16'hBEEF.
- Hit after fill:
  - Stimulus: reads of 0x0100–0x010E immediately after the cold miss.
  - Required: `stall` = 0 and `mem_en` = 0 on every cycle, with data matching memory.
- Write hit:
  - Stimulus: SW 16'h1234 to 0x0106 on a filled line.
  - Required: one cycle with `mem_en` = `mem_wr` = 1, `mem_addr` = 0x0106, `mem_wdata` = 0x1234; the next read of 0x0106 returns 16'h1234 with no stall.
- Write miss:
  - Stimulus: SW 16'h5555 to 0x2000 on a cold cache.
  - Required: memory write issued, `stall` = 0; a subsequent read of 0x2000 misses (13-cycle stall) and returns 16'h5555.
- Conflict eviction:
  - Stimulus: fill 0x0100, then read 0x0500 (same index, NUM_LINES = 64), then read 0x0100 again.
  - Required: both later reads miss with a 13-cycle stall and return correct data.
- Reset mid-fill:
  - Stimulus: pull `rst_n` low during cycle 7 of a fill, release, then read the same address.
  - Required: outputs are 0 during reset; stale `mem_valid` pulses are ignored; the read takes a full 13-cycle miss and returns correct data.
